// File: rtl/izz_dequant_stream.sv
// Zigzag dequantiser and ping-pong reorder buffer feeding the 8x8 IDCT.
// Optional MPEG-2 mismatch control: define IZZ_MISMATCH_EN.
module izz_dequant_stream #(
  parameter int WIN  = 12,
  parameter int WLVL = 12,
  parameter int WQ   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WLVL-1:0]   s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              q_we,
  input  logic [5:0]        q_addr,
  input  logic [WQ-1:0]     q_data,
  output logic [WIN*8-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready
);

  localparam int WP = WLVL + WQ + 1;
  localparam logic signed [WP-1:0] MAXV = WP'(2**(WIN-1) - 1);
  localparam logic signed [WP-1:0] MINV = ~MAXV;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {IDLE, SEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WQ-1:0]     r_qtab [64];
  logic [WIN-1:0]    r_bank [2][64];
  logic [1:0]        r_full;
  logic              r_wsel;
  logic              r_rsel;
  logic [5:0]        r_wcnt;
  logic [2:0]        r_rrow;

  logic              w_acc;
  logic              w_wlast;
  logic              w_rel;
  logic              w_rlast;
  logic signed [WP-1:0] w_lvl;
  logic signed [WP-1:0] w_q;
  logic signed [WP-1:0] w_prod;
  logic signed [WP-1:0] w_shf;
  logic [WIN-1:0]    w_sat;

  assign s_tready = !r_full[r_wsel];
  assign m_tvalid = (r_state == SEND);
  assign w_acc    = s_tvalid && s_tready;
  assign w_wlast  = w_acc && (r_wcnt == 6'd63);
  assign w_rel    = m_tvalid && m_tready;
  assign w_rlast  = w_rel && (r_rrow == 3'd7);

  // Table read is the registered value, so a same-cycle write is not seen.
  always_comb begin
    w_lvl  = {{(WQ+1){s_tdata[WLVL-1]}}, s_tdata};
    w_q    = {{(WLVL+1){1'b0}}, r_qtab[r_wcnt]};
    w_prod = w_lvl * w_q;
    w_shf  = w_prod >>> 4;
    if (w_shf > MAXV)
      w_sat = MAXV[WIN-1:0];
    else if (w_shf < MINV)
      w_sat = MINV[WIN-1:0];
    else
      w_sat = w_shf[WIN-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++)
        r_qtab[i] <= WQ'(16);
    end else if (q_we) begin
      r_qtab[q_addr] <= q_data;
    end
  end

  always_ff @(posedge clock) begin
    if (w_acc)
      r_bank[r_wsel][ZZ[r_wcnt]] <= w_sat;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wcnt <= '0;
      r_wsel <= 1'b0;
    end else if (w_acc) begin
      r_wcnt <= r_wcnt + 6'd1;
      if (r_wcnt == 6'd63)
        r_wsel <= ~r_wsel;
    end
  end

  // Set and clear never target the same bank: a full bank takes no writes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_full <= '0;
    end else begin
      if (w_wlast)
        r_full[r_wsel] <= 1'b1;
      if (w_rlast)
        r_full[r_rsel] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (r_full[r_rsel]) w_state_nxt = SEND;
      SEND: if (w_rlast)        w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rrow <= '0;
      r_rsel <= 1'b0;
    end else if (w_rel) begin
      r_rrow <= r_rrow + 3'd1;
      if (r_rrow == 3'd7)
        r_rsel <= ~r_rsel;
    end
  end

`ifdef IZZ_MISMATCH_EN
  logic       r_prun;
  logic [1:0] r_par;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_prun <= 1'b0;
      r_par  <= '0;
    end else if (w_acc) begin
      r_prun <= (r_wcnt == 6'd0) ? w_sat[0] : (r_prun ^ w_sat[0]);
      if (r_wcnt == 6'd63)
        r_par[r_wsel] <= r_prun ^ w_sat[0];
    end
  end
`endif

  always_comb begin
    m_tdata = '0;
    if (r_state == SEND) begin
      for (int c = 0; c < 8; c++)
        m_tdata[c*WIN +: WIN] = r_bank[r_rsel][{r_rrow, 3'(c)}];
`ifdef IZZ_MISMATCH_EN
      // Even coefficient sum: toggle LSB of the last natural coefficient.
      if (r_rrow == 3'd7 && !r_par[r_rsel])
        m_tdata[7*WIN] = ~m_tdata[7*WIN];
`endif
    end
  end

endmodule

// File: tb/tb_izz_dequant_stream.sv
// Scoreboard bench for izz_dequant_stream with a zigzag/dequant model.
// Honours IZZ_MISMATCH_EN when defined for the whole build.
module tb_izz_dequant_stream;

  localparam int WIN  = 12;
  localparam int WLVL = 12;
  localparam int WQ   = 8;
  localparam int RW   = 8 * WIN;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [WLVL-1:0] s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic            q_we = 1'b0;
  logic [5:0]      q_addr = '0;
  logic [WQ-1:0]   q_data = '0;
  logic [RW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b0;

  izz_dequant_stream #(.WIN(WIN), .WLVL(WLVL), .WQ(WQ)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .q_we(q_we), .q_addr(q_addr), .q_data(q_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  always #5 clock = ~clock;

  int            zz [64];
  logic [WQ-1:0] mq [64];
  logic [WIN-1:0] mblk [64];
  int            mk;
  bit            mpar;
  logic [RW-1:0] expq [$];
  int            nchk;
  int            npass;
  int            rdy_mode;
  bit            acc;

  task automatic chk(input string nm, input logic [RW:0] act,
                     input logic [RW:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Walk the anti-diagonals of the 8x8 block to get the zigzag order.
  task automatic build_zz();
    int i;
    i = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin
          zz[i] = r * 8 + (s - r);
          i++;
        end
      end else begin
        for (int r = hi; r >= lo; r--) begin
          zz[i] = r * 8 + (s - r);
          i++;
        end
      end
    end
  endtask

  function automatic logic [WIN-1:0] dq(input logic [WLVL-1:0] l,
                                        input logic [WQ-1:0] q);
    int p, v;
    p = int'($signed(l)) * int'(q);
    v = p >>> 4;
    if (v > 2**(WIN-1) - 1) v = 2**(WIN-1) - 1;
    if (v < -(2**(WIN-1))) v = -(2**(WIN-1));
    return v[WIN-1:0];
  endfunction

  task automatic model_reset();
    mk = 0;
    mpar = 0;
    for (int i = 0; i < 64; i++) mq[i] = WQ'(16);
  endtask

  task automatic model_beat(input logic [WLVL-1:0] l);
    logic [WIN-1:0] v;
    logic [RW-1:0] row;
    v = dq(l, mq[mk]);
    mblk[zz[mk]] = v;
    mpar ^= v[0];
    mk++;
    if (mk == 64) begin
`ifdef IZZ_MISMATCH_EN
      if (!mpar) mblk[63][0] = ~mblk[63][0];
`endif
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++)
          row[c*WIN +: WIN] = mblk[r*8 + c];
        expq.push_back(row);
      end
      mk = 0;
      mpar = 0;
    end
  endtask

  // One cycle, entered and left at posedge+1.
  task automatic step(input bit v, input logic [WLVL-1:0] l,
                      input bit we, input logic [5:0] a,
                      input logic [WQ-1:0] d, output bit ok);
    s_tvalid = v;
    s_tdata = l;
    q_we = we;
    q_addr = a;
    q_data = d;
    @(negedge clock);
    ok = v && s_tready;
    @(posedge clock);
    #1;
    if (ok) model_beat(l);
    if (we) mq[a] = d;
    s_tvalid = 1'b0;
    q_we = 1'b0;
  endtask

  task automatic send(input logic [WLVL-1:0] l, input bit we,
                      input logic [5:0] a, input logic [WQ-1:0] d);
    bit ok;
    int n;
    step(1'b1, l, we, a, d, ok);
    n = 0;
    while (!ok && n < 500) begin
      step(1'b1, l, 1'b0, 6'd0, '0, ok);
      n++;
    end
    if (!ok) begin
      nchk++;
      $display("FAIL send_timeout: got stalled expected accept");
    end
  endtask

  task automatic write_q(input logic [5:0] a, input logic [WQ-1:0] d);
    step(1'b0, '0, 1'b1, a, d, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || m_tvalid) && n < 2000) begin
      step(1'b0, '0, 1'b0, 6'd0, '0, acc);
      n++;
    end
    chk("drain_rows_left", expq.size(), 0);
  endtask

  task automatic rnd_block(input int gaps, input int wes);
    for (int k = 0; k < 64; k++) begin
      bit we;
      if (gaps != 0 && $urandom_range(0, 3) == 0)
        step(1'b0, '0, 1'b0, 6'd0, '0, acc);
      we = (wes != 0) && ($urandom_range(0, 7) == 0);
      send(WLVL'($urandom), we, 6'($urandom),
           WQ'($urandom_range(1, 40)));
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      m_tready = (rdy_mode == 1) ||
                 (rdy_mode == 2 && $urandom_range(0, 3) != 0);
    end
  end

  bit            pv;
  bit            pr;
  logic [RW-1:0] pd;

  initial begin
    pv = 0;
    pr = 0;
    pd = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv = 0;
      end else begin
        if (pv && !pr)
          chk("hold_stable", {m_tvalid, m_tdata}, {1'b1, pd});
        if (m_tvalid && m_tready) begin
          if (expq.size() == 0) begin
            nchk++;
            $display("FAIL unexpected_row: got %h expected none", m_tdata);
          end else begin
            chk("row", {1'b0, m_tdata}, {1'b0, expq.pop_front()});
          end
        end else if (!m_tvalid) begin
          chk("idle_zero", {1'b0, m_tdata}, '0);
        end
        pv = m_tvalid;
        pr = m_tready;
        pd = m_tdata;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    nchk = 0;
    npass = 0;
    rdy_mode = 1;
    build_zz();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_s_tready", s_tready, 1);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_m_tdata", m_tdata, 0);
    @(posedge clock);
    #1;

    for (int k = 0; k < 64; k++)
      send(WLVL'(k + 1), 1'b0, 6'd0, '0);
    drain();

    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 64; k++) begin
        if (k == 5)
          send(WLVL'(10), b == 0, 6'd5, WQ'(32));
        else
          send(WLVL'($urandom_range(0, 200)), 1'b0, 6'd0, '0);
      end
    end
    drain();

    for (int i = 0; i < 64; i++) write_q(6'(i), WQ'(255));
    for (int k = 0; k < 64; k++) begin
      case (k % 4)
        0: send(WLVL'(2047), 1'b0, 6'd0, '0);
        1: send(WLVL'(-2048), 1'b0, 6'd0, '0);
        2: send(WLVL'(-1), 1'b0, 6'd0, '0);
        default: send(WLVL'($urandom), 1'b0, 6'd0, '0);
      endcase
    end
    for (int i = 0; i < 64; i++)
      write_q(6'(i), (i % 2 == 0) ? WQ'(1) : WQ'(16));
    for (int k = 0; k < 64; k++)
      send((k < 32) ? WLVL'(-1) : WLVL'($urandom),
           1'b0, 6'd0, '0);
    drain();

    rdy_mode = 0;
    cnt = 0;
    for (int i = 0; i < 220; i++) begin
      step(1'b1, WLVL'($urandom), 1'b0, 6'd0, '0, acc);
      if (acc) cnt++;
    end
    chk("bp_accepted", cnt, 128);
    @(negedge clock);
    chk("bp_s_tready", s_tready, 0);
    @(posedge clock);
    #1;
    rdy_mode = 1;
    for (int k = 0; k < 64; k++)
      send(WLVL'($urandom), 1'b0, 6'd0, '0);
    drain();

    rdy_mode = 2;
    for (int b = 0; b < 4; b++) rnd_block(1, 1);
    drain();
    rdy_mode = 1;

    for (int k = 0; k < 30; k++)
      send(WLVL'($urandom), 1'b0, 6'd0, '0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    @(posedge clock);
    #1;
    for (int k = 0; k < 64; k++)
      send((k == 0) ? WLVL'(16) : WLVL'(0), 1'b0, 6'd0, '0);
    for (int k = 0; k < 64; k++)
      send(WLVL'(k + 1), 1'b0, 6'd0, '0);
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
